// File: rtl/any1_pkg.sv
// Shared types for the any1 front end: fetch lines, buffered line entries and
// the aligner-to-decode instruction record.
package any1_pkg;

  localparam int ADDR_W   = 64;
  localparam int STREAM_W = 4;
  localparam int LINE_W   = 128;

  typedef struct packed {
    logic [ADDR_W-1:0]   ip;
    logic [31:0]         ir;
    logic                predict_taken;
    logic [STREAM_W-1:0] stream;
  } sInstAlignOut;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [LINE_W-1:0]   data;
    logic [3:0]          ptaken;
    logic [ADDR_W-1:0]   ptarget;
    logic [STREAM_W-1:0] stream;
  } sFetchLine;

  typedef struct packed {
    sFetchLine  line;
    logic [1:0] start_slot;
    logic [1:0] end_slot;
  } sLineEntry;

  // Lowest predicted-taken slot at or after the entry point, else the last slot.
  function automatic logic [1:0] find_end_slot(input logic [3:0] ptaken,
                                               input logic [1:0] start);
    logic [1:0] end_slot;
    end_slot = 2'd3;
    for (int k = 3; k >= 0; k--) begin
      if (ptaken[k] && (k >= int'(start))) end_slot = 2'(k);
    end
    return end_slot;
  endfunction

endpackage

// File: rtl/any1_line_fifo.sv
// Small circular buffer of fetch-line entries with a registered not-full flag.
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module any1_line_fifo
  import any1_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      clear,
  input  logic      push,
  input  sLineEntry push_entry,
  input  logic      pop,
  output sLineEntry head,
  output logic      empty,
  output logic      not_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  sLineEntry        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // not_full is registered from the next-state count so it is clean for fetch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b0;
    end else begin
      count    <= count_next;
      not_full <= (count_next < FULL_COUNT);
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear) mem[wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/any1_inst_align.sv
// Instruction aligner: buffers fetch lines and hands decode one instruction
// per cycle, honouring redirect entry points and predicted-taken truncation.
module any1_inst_align
  import any1_pkg::*;
#(
  parameter int AWID       = ADDR_W,
  parameter int LINE_INSNS = 4,
  parameter int DEPTH      = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    fl_valid_i,
  output logic                    fl_rdy_o,
  input  logic [AWID-1:0]         fl_addr_i,
  input  logic [32*LINE_INSNS-1:0] fl_data_i,
  input  logic [LINE_INSNS-1:0]   fl_ptaken_i,
  input  logic [AWID-1:0]         fl_ptarget_i,
  input  logic [STREAM_W-1:0]     fl_stream_i,
  input  logic                    flush_i,
  input  logic [AWID-1:0]         flush_ip_i,
  input  logic [STREAM_W-1:0]     flush_stream_i,
  output logic                    a2d_valid_o,
  input  logic                    dec_rdy_i,
  output sInstAlignOut            a2d_out_o,
  output logic [AWID-1:0]         predicted_ip_o
);

  sLineEntry           new_entry;
  sLineEntry           head;
  sLineEntry           src;
  sInstAlignOut        load_out;
  logic [AWID-1:0]     load_pip;
  logic [AWID-1:0]     expected_ip;
  logic [AWID-1:0]     expected_ip_next;
  logic [STREAM_W-1:0] cur_stream;
  logic                fifo_empty;
  logic                fifo_not_full;
  logic                accept_line;
  logic                src_valid;
  logic                load;
  logic                last;
  logic                push;
  logic                pop;
  logic                mid_entry;
  logic [1:0]          slot;
  logic [1:0]          rd_slot;
  logic                unused_bits;

  assign fl_rdy_o = fifo_not_full;

  always_comb begin
    new_entry.line.addr    = fl_addr_i;
    new_entry.line.data    = fl_data_i;
    new_entry.line.ptaken  = fl_ptaken_i;
    new_entry.line.ptarget = fl_ptarget_i;
    new_entry.line.stream  = fl_stream_i;
    new_entry.start_slot   = expected_ip[3:2];
    new_entry.end_slot     = find_end_slot(fl_ptaken_i, expected_ip[3:2]);
  end

  // Lines from the wrong address or stream are consumed but never stored.
  assign accept_line = fl_valid_i && fl_rdy_o && !flush_i
                       && (fl_addr_i[AWID-1:4] == expected_ip[AWID-1:4])
                       && (fl_stream_i == cur_stream);

  always_comb begin
    expected_ip_next = {fl_addr_i[AWID-1:4] + (AWID-4)'(1), 4'h0};
    if (fl_ptaken_i[new_entry.end_slot]) expected_ip_next = fl_ptarget_i;
  end

  // An empty buffer lets the incoming line feed the output register directly.
  assign src       = fifo_empty ? new_entry : head;
  assign src_valid = !fifo_empty || accept_line;
  assign rd_slot   = mid_entry ? slot : src.start_slot;
  assign last      = (rd_slot == src.end_slot);
  assign load      = !flush_i && src_valid && (!a2d_valid_o || dec_rdy_i);
  assign push      = accept_line && !(fifo_empty && load && last);
  assign pop       = load && last && !fifo_empty;

  always_comb begin
    load_out.ip            = {src.line.addr[AWID-1:4], rd_slot, 2'b00};
    load_out.ir            = src.line.data[32*rd_slot +: 32];
    load_out.predict_taken = src.line.ptaken[rd_slot];
    load_out.stream        = cur_stream;
    load_pip               = load_out.ip + AWID'(4);
    if (load_out.predict_taken) load_pip = src.line.ptarget;
  end

  any1_line_fifo #(
    .DEPTH(DEPTH)
  ) u_line_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (flush_i),
    .push      (push),
    .push_entry(new_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .not_full  (fifo_not_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a2d_valid_o    <= 1'b0;
      a2d_out_o      <= '0;
      predicted_ip_o <= '0;
      expected_ip    <= '0;
      cur_stream     <= '0;
      mid_entry      <= 1'b0;
      slot           <= '0;
    end else if (flush_i) begin
      a2d_valid_o <= 1'b0;
      expected_ip <= flush_ip_i;
      cur_stream  <= flush_stream_i;
      mid_entry   <= 1'b0;
      slot        <= '0;
    end else begin
      if (accept_line) expected_ip <= expected_ip_next;
      if (load) begin
        a2d_valid_o    <= 1'b1;
        a2d_out_o      <= load_out;
        predicted_ip_o <= load_pip;
        mid_entry      <= !last;
        slot           <= rd_slot + 2'd1;
      end else if (dec_rdy_i) begin
        a2d_valid_o <= 1'b0;
      end
    end
  end

  assign unused_bits = ^{expected_ip[1:0], src.line.addr[3:0], src.line.stream};

endmodule

// File: tb/tb_any1_inst_align.sv
// Directed self-checking bench for any1_inst_align: inputs are driven and
// outputs are sampled on the falling clock edge.
module tb_any1_inst_align;
  import any1_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                fl_valid = 1'b0;
  logic                fl_rdy;
  logic [63:0]         fl_addr = '0;
  logic [127:0]        fl_data = '0;
  logic [3:0]          fl_ptaken = '0;
  logic [63:0]         fl_ptarget = '0;
  logic [STREAM_W-1:0] fl_stream = '0;
  logic                flush = 1'b0;
  logic [63:0]         flush_ip = '0;
  logic [STREAM_W-1:0] flush_stream = '0;
  logic                a2d_valid;
  logic                dec_rdy = 1'b1;
  sInstAlignOut        a2d_out;
  logic [63:0]         predicted_ip;

  int checkCount = 0;
  int passCount  = 0;

  any1_inst_align dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fl_valid_i    (fl_valid),
    .fl_rdy_o      (fl_rdy),
    .fl_addr_i     (fl_addr),
    .fl_data_i     (fl_data),
    .fl_ptaken_i   (fl_ptaken),
    .fl_ptarget_i  (fl_ptarget),
    .fl_stream_i   (fl_stream),
    .flush_i       (flush),
    .flush_ip_i    (flush_ip),
    .flush_stream_i(flush_stream),
    .a2d_valid_o   (a2d_valid),
    .dec_rdy_i     (dec_rdy),
    .a2d_out_o     (a2d_out),
    .predicted_ip_o(predicted_ip)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Slot k of every line carries base+k so each instruction is recognisable.
  task automatic applyStimulus(input logic [63:0] addr, input logic [31:0] base,
                               input logic [3:0] ptaken, input logic [63:0] ptarget,
                               input logic [STREAM_W-1:0] stream);
    fl_valid   = 1'b1;
    fl_addr    = addr;
    fl_data    = {base + 32'd3, base + 32'd2, base + 32'd1, base};
    fl_ptaken  = ptaken;
    fl_ptarget = ptarget;
    fl_stream  = stream;
  endtask

  task automatic applyFlush(input logic [63:0] ip, input logic [STREAM_W-1:0] stream);
    flush        = 1'b1;
    flush_ip     = ip;
    flush_stream = stream;
    step();
    flush = 1'b0;
  endtask

  task automatic expectInst(input string tag, input logic [63:0] ip, input logic [31:0] ir,
                            input logic pt, input logic [63:0] pip,
                            input logic [STREAM_W-1:0] stream);
    checkOutput({tag, ".valid"}, 64'(a2d_valid), 64'd1);
    checkOutput({tag, ".ip"}, a2d_out.ip, ip);
    checkOutput({tag, ".ir"}, 64'(a2d_out.ir), 64'(ir));
    checkOutput({tag, ".ptaken"}, 64'(a2d_out.predict_taken), 64'(pt));
    checkOutput({tag, ".pred_ip"}, predicted_ip, pip);
    checkOutput({tag, ".stream"}, 64'(a2d_out.stream), 64'(stream));
  endtask

  // Consecutive not-taken instructions, one per cycle with decode ready.
  task automatic expectRun(input string tag, input logic [63:0] first_ip,
                           input logic [31:0] base, input int first_slot, input int n,
                           input logic [STREAM_W-1:0] stream);
    for (int i = 0; i < n; i++) begin
      expectInst($sformatf("%s.%0d", tag, i), first_ip + 64'(4 * i),
                 base + 32'(first_slot + i), 1'b0, first_ip + 64'(4 * i + 4), stream);
      step();
    end
  endtask

  initial begin : main
    logic [31:0] bases [3];
    logic        accepted;
    bases[0] = 32'hF000_0000;
    bases[1] = 32'h6000_0000;
    bases[2] = 32'h4000_0000;

    // Reset state
    step();
    step();
    checkOutput("rst.valid", 64'(a2d_valid), 64'd0);
    checkOutput("rst.fl_rdy", 64'(fl_rdy), 64'd0);
    checkOutput("rst.ip", a2d_out.ip, 64'd0);
    checkOutput("rst.pred_ip", predicted_ip, 64'd0);
    rst_n = 1'b1;
    checkOutput("rst.rdy_before_clk", 64'(fl_rdy), 64'd0);
    step();
    checkOutput("rst.rdy_after_clk", 64'(fl_rdy), 64'd1);

    // Straight-line fetch, first output one cycle after accept
    applyFlush(64'h1000, 4'd0);
    checkOutput("s1.flush_valid", 64'(a2d_valid), 64'd0);
    applyStimulus(64'h1000, 32'hA000_0000, 4'b0000, 64'h0, 4'd0);
    step();
    fl_valid = 1'b0;
    expectRun("s1", 64'h1000, 32'hA000_0000, 0, 4, 4'd0);
    checkOutput("s1.drained", 64'(a2d_valid), 64'd0);

    // Mid-line entry after redirect, then a stale line
    applyFlush(64'h2008, 4'd3);
    applyStimulus(64'h2000, 32'hB000_0000, 4'b0000, 64'h0, 4'd3);
    step();
    fl_valid = 1'b0;
    expectRun("s2", 64'h2008, 32'hB000_0000, 2, 2, 4'd3);
    checkOutput("s2.drained", 64'(a2d_valid), 64'd0);
    applyStimulus(64'h1010, 32'hBB00_0000, 4'b0000, 64'h0, 4'd0);
    step();
    fl_valid = 1'b0;
    checkOutput("s2.stale_rdy", 64'(fl_rdy), 64'd1);
    step();
    checkOutput("s2.stale_valid0", 64'(a2d_valid), 64'd0);
    step();
    checkOutput("s2.stale_valid1", 64'(a2d_valid), 64'd0);

    // Predicted-taken truncation and the target line
    applyFlush(64'h3000, 4'd1);
    applyStimulus(64'h3000, 32'hC000_0000, 4'b0010, 64'h5004, 4'd1);
    step();
    fl_valid = 1'b0;
    expectInst("s3.0", 64'h3000, 32'hC000_0000, 1'b0, 64'h3004, 4'd1);
    step();
    expectInst("s3.1", 64'h3004, 32'hC000_0001, 1'b1, 64'h5004, 4'd1);
    step();
    checkOutput("s3.truncated", 64'(a2d_valid), 64'd0);
    applyStimulus(64'h5000, 32'hD000_0000, 4'b0000, 64'h0, 4'd1);
    step();
    fl_valid = 1'b0;
    expectRun("s3t", 64'h5004, 32'hD000_0000, 1, 3, 4'd1);
    checkOutput("s3t.drained", 64'(a2d_valid), 64'd0);

    // Taken slots before the entry point do not truncate
    applyFlush(64'h6008, 4'd1);
    applyStimulus(64'h6000, 32'hE000_0000, 4'b0011, 64'hDEAD_0000, 4'd1);
    step();
    fl_valid = 1'b0;
    expectRun("s3b", 64'h6008, 32'hE000_0000, 2, 2, 4'd1);
    checkOutput("s3b.drained", 64'(a2d_valid), 64'd0);

    // Decode stalled for 10 cycles with three lines offered
    dec_rdy = 1'b0;
    applyFlush(64'h7000, 4'd2);
    applyStimulus(64'h7000, bases[0], 4'b0000, 64'h0, 4'd2);
    step();
    checkOutput("s4.rdy_one", 64'(fl_rdy), 64'd1);
    applyStimulus(64'h7010, bases[1], 4'b0000, 64'h0, 4'd2);
    step();
    applyStimulus(64'h7020, bases[2], 4'b0000, 64'h0, 4'd2);
    for (int j = 0; j < 7; j++) begin
      checkOutput($sformatf("s4.stall%0d.rdy", j), 64'(fl_rdy), 64'd0);
      checkOutput($sformatf("s4.stall%0d.valid", j), 64'(a2d_valid), 64'd1);
      checkOutput($sformatf("s4.stall%0d.ip", j), a2d_out.ip, 64'h7000);
      checkOutput($sformatf("s4.stall%0d.ir", j), 64'(a2d_out.ir), 64'(bases[0]));
      step();
    end
    dec_rdy = 1'b1;
    for (int i = 1; i < 12; i++) begin
      accepted = fl_valid && fl_rdy;
      step();
      if (accepted) fl_valid = 1'b0;
      expectInst($sformatf("s4.out%0d", i), 64'h7000 + 64'(4 * i),
                 bases[i / 4] + 32'(i % 4), 1'b0, 64'h7004 + 64'(4 * i), 4'd2);
    end
    step();
    checkOutput("s4.drained", 64'(a2d_valid), 64'd0);

    // Flush colliding with a line accept and a decoder pop
    applyFlush(64'h8000, 4'd0);
    applyStimulus(64'h8000, 32'h8800_0000, 4'b0000, 64'h0, 4'd0);
    step();
    fl_valid = 1'b0;
    expectInst("s5.pre", 64'h8000, 32'h8800_0000, 1'b0, 64'h8004, 4'd0);
    applyStimulus(64'h8010, 32'h8900_0000, 4'b0000, 64'h0, 4'd0);
    applyFlush(64'h9000, 4'd1);
    fl_valid = 1'b0;
    checkOutput("s5.valid0", 64'(a2d_valid), 64'd0);
    step();
    checkOutput("s5.valid1", 64'(a2d_valid), 64'd0);
    checkOutput("s5.rdy", 64'(fl_rdy), 64'd1);
    step();
    checkOutput("s5.valid2", 64'(a2d_valid), 64'd0);
    applyStimulus(64'h9000, 32'h9900_0000, 4'b0000, 64'h0, 4'd1);
    step();
    fl_valid = 1'b0;
    expectInst("s5.post", 64'h9000, 32'h9900_0000, 1'b0, 64'h9004, 4'd1);

    // Asynchronous reset in the middle of a line
    applyFlush(64'hA000, 4'd0);
    applyStimulus(64'hA000, 32'hAA00_0000, 4'b0000, 64'h0, 4'd0);
    step();
    fl_valid = 1'b0;
    expectInst("s6.pre", 64'hA000, 32'hAA00_0000, 1'b0, 64'hA004, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6.async_valid", 64'(a2d_valid), 64'd0);
    checkOutput("s6.async_rdy", 64'(fl_rdy), 64'd0);
    checkOutput("s6.async_ip", a2d_out.ip, 64'd0);
    step();
    #2 rst_n = 1'b1;
    #1;
    checkOutput("s6.rel_rdy", 64'(fl_rdy), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("s6.clk_rdy", 64'(fl_rdy), 64'd1);
    checkOutput("s6.clk_valid", 64'(a2d_valid), 64'd0);
    step();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/any1_inst_align.md
Name: any1_inst_align

Overview:
- Producer side of the aligner-to-decode interface.
- Accepts 128-bit fetch lines (4 x 32-bit instructions) from the fetch stage and emits one instruction per cycle as sInstAlignOut, plus the predicted next IP, to the decode stage.
- Holds up to two fetch lines, handles mid-line entry after redirects, and truncates a line after a predicted-taken branch.
- Discards stale lines on flush.

Parameters:
- AWID, 64, address width (matches Address).
- LINE_INSNS, 4, instructions per fetch line; fixed at 4 in this revision.
- DEPTH, 2, line buffer entries; power of two.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- fl_valid_i  in  1  fetch line valid
- fl_rdy_o  out  1  aligner can accept a line this cycle
- fl_addr_i  in  AWID  line address; bits [3:0] ignored
- fl_data_i  in  128  line data; slot k = bits [32k+31:32k]
- fl_ptaken_i  in  4  per-slot predicted-taken flags
- fl_ptarget_i  in  AWID  predicted target for the first taken slot
- fl_stream_i  in  STREAM_W  stream tag of the line
- flush_i  in  1  redirect: drop all buffered state
- flush_ip_i  in  AWID  redirect address; bits [1:0] zero
- flush_stream_i  in  STREAM_W  stream tag after redirect
- a2d_valid_o  out  1  a2d_out holds a valid instruction
- dec_rdy_i  in  1  decoder accepts a2d_out this cycle
- a2d_out_o  out  sInstAlignOut  ip, ir, predict_taken, Stream
- predicted_ip_o  out  AWID  ptarget if predict_taken, else ip+4

Behaviour:
- Reset (rst_ni low, asynchronous):
  - buffer empty, rd/wr pointers 0, a2d_valid_o=0, a2d_out_o all zero, predicted_ip_o=0.
  - expected_ip=0, cur_stream=0, fl_rdy_o=0.
  - fl_rdy_o becomes 1 on the first clock after reset release.
- Line accept: occurs when fl_valid_i & fl_rdy_o.
  - fl_rdy_o is registered and equals (count < DEPTH) computed from next-state count.
  - A line is written only if fl_addr_i[AWID-1:4]==expected_ip[AWID-1:4] and fl_stream_i==cur_stream; otherwise it is accepted and discarded (stale).
  - Written entry start slot = expected_ip[3:2].
  - Entry end slot = first slot >= start with ptaken set, else 3.
  - After a write, expected_ip = ptarget if the truncating slot was taken, else {line+1, 4'h0}.
- Output register:
  - Loads when !a2d_valid_o or (a2d_valid_o & dec_rdy_i), and the head entry exists.
  - Load fields: ip={line,slot,2'b00}; ir=slot data; predict_taken=ptaken[slot]; Stream=cur_stream; predicted_ip as per the port definition.
  - Slot advances; when slot passes end slot the entry pops.
  - Latency: an accepted line yields its first instruction on a2d_out_o one cycle after accept (empty pipe).
  - Throughput: 1 instruction/cycle.
  - a2d_out_o is held stable while a2d_valid_o & !dec_rdy_i.
- Simultaneous write and pop: allowed, count unchanged. Writing into a full buffer cannot occur because fl_rdy_o gates it.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Line address increment wraps modulo 2^AWID.
- Flush (highest priority):
  - Takes effect at the next edge: buffer emptied, a2d_valid_o=0, expected_ip=flush_ip_i, cur_stream=flush_stream_i.
  - A line presented in the flush cycle is dropped.
  - dec_rdy_i in the flush cycle is ignored.
  - The first instruction after flush uses slot flush_ip_i[3:2].
- A taken slot with start > its index is not a truncation candidate (only slots >= start count).
- Reset mid-operation: all state is cleared immediately, with no partial output.

Decomposition:
- any1_pkg gains:
  - sFetchLine typedef (addr, data, ptaken, ptarget, stream)
  - STREAM_W localparam
  - the sInstAlignOut definition, if not already exported
- Sub-module any1_line_fifo: DEPTH-entry FIFO of sFetchLine plus start/end slot, with count and registered not-full.
- Slot sequencing and output register stay in the top module.

Test Plan:
- Reset then line addr 0x1000, data slots {A0,A1,A2,A3}, ptaken=0 -> 4 outputs ip 0x1000..0x100C, predicted_ip 0x1004..0x1010, first output one cycle after accept.
- Flush ip 0x2008, stream 3, then line 0x2000 -> outputs only 0x2008, 0x200C with Stream=3; a line 0x1010 with stream 0 presented afterwards is discarded.
- Line 0x3000 with ptaken=4'b0010, ptarget 0x5004 -> outputs 0x3000, 0x3004 (predict_taken=1, predicted_ip 0x5004). Next line 0x5000 emits from 0x5004.
- dec_rdy_i low for 10 cycles with three lines offered -> two accepted, fl_rdy_o drops to 0, a2d_out_o stable. Releasing resumes in order with no loss.
- flush_i asserted in the same cycle as a line accept and a decoder pop -> next cycle a2d_valid_o=0, buffer empty, the line is not emitted.
- rst_ni pulsed low asynchronously mid-stream -> a2d_valid_o and fl_rdy_o go 0 without a clock edge; the first clock after release shows fl_rdy_o=1.
